// File: rtl/apb_pkg.sv
// apb_pkg: shared types and default widths for the APB request arbiter.
// The FSM encoding is visible on the arbiter's dbg_state port.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 32;

endpackage

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: combinational round-robin pick. The search starts at
// last+1 and wraps modulo NREQ. The output is a one-hot grant, its encoded
// index, and a flag that is set when any request is present. The pointer
// register lives in the parent.
module apb_rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    any
);

    localparam int IDX_W = $clog2(NREQ);

    // Walk NREQ candidates after last; the first active one wins.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] c;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(last) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            c = IDX_W'(cand);
            if (!any && req[c]) begin
                any      = 1'b1;
                grant[c] = 1'b1;
                idx      = c;
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin front end that lets NREQ local requesters
// share one APB master port. It sequences transfers through IDLE/SETUP/ACCESS.
// Optional feature: define APB_ARB_TIMEOUT_EN to abort ACCESS after
// TIMEOUT wait cycles. The aborted transfer completes with rsp_err = 1.
//
// Handshake: a requester holds req_valid with a stable command until
// req_ready is high in the same cycle. That cycle is the acceptance.
// Dropping req_valid before acceptance withdraws the request. rsp_valid is
// a one-cycle pulse to the accepted requester and takes no back-pressure.
module apb_req_arbiter
    import apb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ-1:0]        req_write,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic                   PSEL,
    output logic                   PENABLE,
    output logic                   PWRITE,
    output logic [ADDR_W-1:0]      PADDR,
    output logic [DATA_W-1:0]      PWDATA,
    input  logic [DATA_W-1:0]      PRDATA,
    input  logic                   PREADY,
    output logic [1:0]             dbg_state
);

    localparam int IDX_W = $clog2(NREQ);

    apb_state_e       state, state_nxt;
    logic [IDX_W-1:0] last;
    logic [NREQ-1:0]  gnt_oh;
    logic [NREQ-1:0]  pend_mask, arb_req, arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any, arb_en, do_grant, xfer_done, abort;

    // While a transfer is in ACCESS, its requester has been accepted but has
    // not yet seen rsp_valid. Exclude it from the pick.
    assign pend_mask = (state == ACCESS) ? gnt_oh : '0;
    assign arb_req   = req_valid & ~pend_mask;
    assign arb_en    = (state == IDLE) || ((state == ACCESS) && PREADY);
    assign do_grant  = arb_en && arb_any;
    assign xfer_done = (state == ACCESS) && PREADY;
    assign req_ready = do_grant ? arb_grant : '0;
    assign dbg_state = state;

    apb_rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (arb_req),
        .last  (last),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             rsp_err_q;

    // Count consecutive ACCESS wait cycles. The count clears while in SETUP, so each ACCESS phase starts at zero.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if ((state == ACCESS) && !PREADY) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Abort on the TIMEOUT-th wait cycle. A PREADY on that same cycle still completes the transfer normally.
    assign abort = (state == ACCESS) && !PREADY && (wait_cnt == CNT_W'(TIMEOUT - 1));

    // Error flag travels with the completion pulse.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= abort;
        end
    end
    assign rsp_err = rsp_err_q;
`else
    assign abort   = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. A grant in the PREADY cycle makes the next SETUP follow immediately.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = do_grant ? SETUP : IDLE;
            SETUP:   state_nxt = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    state_nxt = do_grant ? SETUP : IDLE;
                end else if (abort) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // APB phase outputs decode from state alone.
    always_comb begin
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        case (state)
            SETUP:  PSEL = 1'b1;
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
            end
            default: ;
        endcase
    end

    // On a grant, latch the winner's command and advance the pointer. Otherwise hold everything.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
            last   <= IDX_W'(NREQ - 1);
            gnt_oh <= '0;
        end else if (do_grant) begin
            PADDR  <= req_addr[arb_idx*ADDR_W +: ADDR_W];
            PWRITE <= req_write[arb_idx];
            PWDATA <= req_wdata[arb_idx*DATA_W +: DATA_W];
            last   <= arb_idx;
            gnt_oh <= arb_grant;
        end
    end

    // Registered completion one cycle after PREADY or after an abort. Read data is zero for writes and for aborts.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= (xfer_done || abort) ? gnt_oh : '0;
            rsp_rdata <= (xfer_done && !PWRITE) ? PRDATA : '0;
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: bench for apb_req_arbiter. It uses a round-robin
// vector table plus hand-written sequences for reset, wait states,
// back-to-back transfers and the optional timeout (APB_ARB_TIMEOUT_EN).
module tb_apb_req_arbiter;
    import apb_pkg::*;

    localparam int NREQ    = 4;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;
    localparam int EXP_W   = NREQ + DATA_W + 1;

    // ---------------- clock / reset ----------------
    logic PCLK   = 1'b0;
    logic PRESET = 1'b1;
    always #5 PCLK = ~PCLK;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ-1:0]        req_write;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   rsp_err;
    logic                   PSEL, PENABLE, PWRITE;
    logic [ADDR_W-1:0]      PADDR;
    logic [DATA_W-1:0]      PWDATA;
    logic [DATA_W-1:0]      PRDATA;
    logic                   PREADY;
    logic [1:0]             dbg_state;

    apb_req_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_addr(req_addr), .req_write(req_write),
        .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] mon_e;

    int               slave_waits = 0;
    logic             slave_hold  = 1'b0;
    logic [DATA_W-1:0] slave_rdata = '0;
    int               slv_wcnt    = 0;

    typedef struct {
        logic [NREQ-1:0] valid;
        logic [NREQ-1:0] write;
        int              waits;
        int              exp_win;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [ADDR_W-1:0] addr_of(input int i);
        return ADDR_W'(32'h40 + 4 * i);
    endfunction

    function automatic logic [DATA_W-1:0] wdata_of(input int i);
        return DATA_W'(32'hA5A5_0000 + i * 32'h1111);
    endfunction

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // ---------------- APB slave model ----------------
    initial begin
        PREADY = 1'b0;
        PRDATA = '0;
        forever begin
            @(posedge PCLK);
            #1;
            PRDATA = slave_rdata;
            if (PSEL && PENABLE && !slave_hold) begin
                if (slv_wcnt < slave_waits) begin
                    PREADY = 1'b0;
                    slv_wcnt++;
                end else begin
                    PREADY   = 1'b1;
                    slv_wcnt = 0;
                end
            end else begin
                PREADY   = 1'b0;
                slv_wcnt = 0;
            end
        end
    end

    // ---------------- response monitor ----------------
    always @(negedge PCLK) begin
        if (!PRESET) begin
            checks++;
            if (!$onehot0(req_ready)) begin
                failures++;
                $display("FAIL req_ready_onehot act=%b exp=onehot0", req_ready);
            end
            if (rsp_valid !== '0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp act=%b exp=none at %0t", rsp_valid, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp", {rsp_valid, rsp_rdata, rsp_err}, mon_e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge PCLK);
        #2;
    endtask

    task automatic smp();
        @(negedge PCLK);
    endtask

    task automatic set_cmds();
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*ADDR_W +: ADDR_W]  = addr_of(i);
            req_wdata[i*DATA_W +: DATA_W] = wdata_of(i);
        end
    endtask

    task automatic do_reset(input int cyc);
        PRESET    = 1'b1;
        req_valid = '0;
        exp_q.delete();
        repeat (cyc) @(posedge PCLK);
        #2;
        PRESET = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        check({name, "_drain"}, 64'(exp_q.size()), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        // Round-robin table. The pointer starts at 3 after reset, and each row
        // moves it to that row's winner.
        vecs[0] = '{4'b1010, 4'b0000, 0, 1};
        vecs[1] = '{4'b1010, 4'b1010, 1, 3};
        vecs[2] = '{4'b0110, 4'b0100, 2, 1};
        vecs[3] = '{4'b0011, 4'b0001, 0, 0};
        vecs[4] = '{4'b1001, 4'b0000, 1, 3};
        vecs[5] = '{4'b1111, 4'b1111, 0, 0};
        vecs[6] = '{4'b0001, 4'b0000, 0, 0};
        vecs[7] = '{4'b0100, 4'b0100, 2, 2};

        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset state.
        repeat (2) @(posedge PCLK);
        smp();
        check("rst_psel",    PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_pwrite",  PWRITE, 0);
        check("rst_paddr",   PADDR, 0);
        check("rst_pwdata",  PWDATA, 0);
        check("rst_ready",   req_ready, 0);
        check("rst_rspv",    rsp_valid, 0);
        check("rst_rdata",   rsp_rdata, 0);
        check("rst_err",     rsp_err, 0);
        check("rst_state",   dbg_state, 0);
        @(posedge PCLK);
        #2;
        PRESET = 1'b0;

        // Single read from req 2 at 0x3C, zero-wait slave.
        tick();
        set_cmds();
        req_addr[2*ADDR_W +: ADDR_W] = 8'h3C;
        req_write   = '0;
        req_valid   = 4'b0100;
        slave_waits = 0;
        slave_rdata = 32'hDEAD_BEEF;
        exp_q.push_back({4'b0100, 32'hDEAD_BEEF, 1'b0});
        smp();
        check("t1_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        smp();
        check("t1_setup", {PSEL, PENABLE}, 2'b10);
        check("t1_paddr", PADDR, 8'h3C);
        check("t1_pwrite", PWRITE, 0);
        tick();
        smp();
        check("t1_access", {PSEL, PENABLE}, 2'b11);
        tick();
        smp();
        check("t1_rspv", rsp_valid, 4'b0100);
        check("t1_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check("t1_idle", {PSEL, PENABLE}, 2'b00);
        wait_drain("t1", 5);

        // Round-robin table.
        do_reset(2);
        for (int i = 0; i < 8; i++) begin
            tick();
            set_cmds();
            slave_waits = vecs[i].waits;
            slave_rdata = 32'h1000_0000 + 32'(i);
            req_write   = vecs[i].write;
            req_valid   = vecs[i].valid;
            exp_q.push_back({oh(vecs[i].exp_win),
                             vecs[i].write[vecs[i].exp_win] ? 32'h0 : slave_rdata, 1'b0});
            smp();
            check("tbl_grant", req_ready, oh(vecs[i].exp_win));
            tick();
            req_valid = '0;
            smp();
            check("tbl_paddr",  PADDR, addr_of(vecs[i].exp_win));
            check("tbl_pwdata", PWDATA, wdata_of(vecs[i].exp_win));
            check("tbl_pwrite", PWRITE, vecs[i].write[vecs[i].exp_win]);
            wait_drain("tbl", 20);
        end

        // All four requesters continuously valid with writes: grant order 0,1,2,3,0.
        do_reset(2);
        tick();
        set_cmds();
        slave_waits = 0;
        req_write   = 4'b1111;
        req_valid   = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back({oh(k % NREQ), 32'h0, 1'b0});
            smp();
            check("b2b_grant", req_ready, oh(k % NREQ));
            if (k > 0) check("b2b_psel_acc", {PSEL, PENABLE}, 2'b11);
            tick();
            if (k == 4) req_valid = '0;
            smp();
            check("b2b_noready", req_ready, 0);
            check("b2b_setup", {PSEL, PENABLE}, 2'b10);
            check("b2b_pwdata", PWDATA, wdata_of(k % NREQ));
            tick();
        end
        wait_drain("b2b", 10);

        // Write from req 1 with 3 wait states.
        tick();
        set_cmds();
        slave_waits = 3;
        req_write   = 4'b0010;
        req_valid   = 4'b0010;
        exp_q.push_back({4'b0010, 32'h0, 1'b0});
        smp();
        check("ws_ready", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        smp();
        check("ws_setup", {PSEL, PENABLE}, 2'b10);
        for (int a = 0; a < 4; a++) begin
            tick();
            smp();
            check("ws_access", {PSEL, PENABLE}, 2'b11);
            check("ws_paddr",  PADDR, addr_of(1));
            check("ws_pwdata", PWDATA, wdata_of(1));
            check("ws_pwrite", PWRITE, 1);
            check("ws_norsp",  rsp_valid, 0);
        end
        tick();
        smp();
        check("ws_rspv",  rsp_valid, 4'b0010);
        check("ws_rdata", rsp_rdata, 0);
        check("ws_idle",  PSEL, 0);
        tick();
        smp();
        check("ws_paddr_hold", PADDR, addr_of(1));
        wait_drain("ws", 5);

        // Reset pulse during ACCESS of req 0.
        tick();
        slave_waits = 5;
        slave_rdata = 32'h0BAD_F00D;
        req_write   = '0;
        req_valid   = 4'b0001;
        exp_q.push_back({4'b0001, 32'h0BAD_F00D, 1'b0});
        smp();
        check("rs_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        tick();
        smp();
        check("rs_access", {PSEL, PENABLE}, 2'b11);
        tick();
        PRESET = 1'b1;
        exp_q.delete();
        #1;
        check("rs_drop", {PSEL, PENABLE}, 2'b00);
        smp();
        check("rs_norsp", rsp_valid, 0);
        tick();
        tick();
        PRESET    = 1'b0;
        req_valid = 4'b1111;
        smp();
        check("rs_regrant", req_ready, 4'b0001);
        check("rs_norsp2",  rsp_valid, 0);
        exp_q.push_back({4'b0001, 32'h0BAD_F00D, 1'b0});
        tick();
        req_valid = '0;
        wait_drain("rs", 20);

`ifdef APB_ARB_TIMEOUT_EN
        // PREADY on the limit cycle completes normally.
        tick();
        slave_waits = TIMEOUT - 1;
        slave_rdata = 32'h5A5A_0001;
        req_write   = '0;
        req_valid   = 4'b0100;
        exp_q.push_back({4'b0100, 32'h5A5A_0001, 1'b0});
        smp();
        check("toe_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        wait_drain("toe", TIMEOUT + 10);

        // PREADY held low: abort after TIMEOUT ACCESS cycles.
        tick();
        slave_hold = 1'b1;
        req_valid  = 4'b1000;
        exp_q.push_back({4'b1000, 32'h0, 1'b1});
        smp();
        check("to_ready", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        for (int a = 0; a < TIMEOUT; a++) begin
            tick();
            smp();
            check("to_access", {PSEL, PENABLE}, 2'b11);
        end
        tick();
        smp();
        check("to_psel_drop", PSEL, 0);
        check("to_rspv", rsp_valid, 4'b1000);
        check("to_err",  rsp_err, 1);
        slave_hold = 1'b0;
        wait_drain("to", 5);
`else
        // PREADY held low: ACCESS waits indefinitely with no response.
        tick();
        slave_hold = 1'b1;
        req_write  = '0;
        req_valid  = 4'b1000;
        smp();
        check("nto_ready", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        for (int a = 0; a < 100; a++) begin
            tick();
            smp();
            check("nto_hold", {PSEL, PENABLE}, 2'b11);
            check("nto_norsp", rsp_valid, 0);
        end
        do_reset(2);
        slave_hold = 1'b0;
`endif

        tick();
        tick();
        check("final_queue", 64'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Multi-requester APB master front end. NREQ local requesters each present a single-transfer command (address, direction, write data), and the block grants one at a time by round-robin. It sequences the winning transfer through the APB IDLE/SETUP/ACCESS phases on one shared APB port and returns the read data or completion to the winner. It sits between on-chip masters and the APB slave fabric.

## Interface
- NREQ, 4: number of requesters (2..8)
- ADDR_W, 8: PADDR width
- DATA_W, 32: PWDATA/PRDATA width
- TIMEOUT, 16: ACCESS-phase wait limit in cycles; used only with APB_ARB_TIMEOUT_EN
- PCLK  in  1  single clock, rising edge
- PRESET  in  1  reset; asynchronous, active-high
- req_valid  in  NREQ  per-requester command valid; held until accepted
- req_addr  in  NREQ*ADDR_W  flattened; slice i belongs to requester i
- req_write  in  NREQ  1 = write, 0 = read
- req_wdata  in  NREQ*DATA_W  flattened write data
- req_ready  out  NREQ  one-hot accept pulse
- rsp_valid  out  NREQ  one-hot one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data; valid with rsp_valid, 0 for writes
- rsp_err  out  1  timeout abort flag; valid with rsp_valid
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB transfer complete

## Operation
- Reset values: state IDLE. PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready, rsp_valid, rsp_rdata and rsp_err are all 0. Grant pointer last = NREQ-1, so requester 0 has first priority.
- The state machine has three states: IDLE, SETUP and ACCESS.
- PSEL and PENABLE decode from state only: IDLE = 00, SETUP = 10, ACCESS = 11.
- Arbitration runs in IDLE, and in ACCESS on the PREADY cycle.
  - The winner is the first requester with req_valid set, searching from last+1 and wrapping modulo NREQ.
  - Grant actions: req_ready[winner] = 1 combinationally, addr/write/wdata latched into PADDR/PWRITE/PWDATA, last ← winner, next state SETUP.
- SETUP always moves to ACCESS.
- ACCESS with PREADY = 1:
  - Registered response next cycle: rsp_valid[granted] = 1, rsp_rdata = PRDATA for reads and 0 for writes, rsp_err = 0.
  - Next state is SETUP if any req_valid is set (back-to-back transfer), otherwise IDLE.
- ACCESS with PREADY = 0: hold state and keep all APB outputs stable.
- PADDR, PWRITE and PWDATA change only on a grant. They hold their last value while idle.
- A requester whose grant is pending cannot be granted again until its rsp_valid pulse.
- Deasserting req_valid before acceptance withdraws the request with no side effects.

## Timing
- Accept at cycle T (req_ready high). SETUP runs at T+1 and ACCESS at T+2.
- With a zero-wait slave, PREADY is high at T+2 and rsp_valid is high at T+3. Each wait state adds one cycle.
- Back-to-back throughput is one transfer per 2 cycles. The next SETUP overlaps the previous transfer's rsp_valid cycle.
- When several requesters are valid at once, exactly one req_ready is asserted.
- Asserting PRESET mid-transfer drops PSEL and PENABLE immediately. The in-flight response is discarded and no rsp_valid is generated.

## Configuration
- APB_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY = 0.
  - After TIMEOUT consecutive wait cycles without PREADY, the transfer aborts and the next state is IDLE.
  - The abort produces rsp_valid[granted] = 1 next cycle with rsp_err = 1 and rsp_rdata = 0.
  - PREADY arriving on the cycle the limit is reached wins: normal completion.
- APB_ARB_TIMEOUT_EN undefined: there is no counter, rsp_err is tied to 0, and ACCESS waits indefinitely.

## Structure
- Shared package apb_pkg holds:
  - the typedef enum logic [1:0] apb_state_e {IDLE, SETUP, ACCESS};
  - default ADDR_W and DATA_W localparams.
- Sub-module apb_rr_arbiter(NREQ): inputs req and last pointer, outputs one-hot grant plus encoded index. It is combinational. The pointer register stays in the top level.

## Test plan
- Single read from req 2 at 0x3C, zero-wait slave, PRDATA = 0xDEADBEEF -> req_ready[2] at T, PSEL/PENABLE 10 at T+1 and 11 at T+2, rsp_valid[2] with rsp_rdata = 0xDEADBEEF at T+3.
- All four requesters valid continuously with writes -> grant order 0,1,2,3,0, one transfer every 2 cycles, PSEL never drops.
- Write from req 1, slave inserts 3 wait states -> PADDR/PWDATA/PWRITE stable for 4 ACCESS cycles, rsp_valid[1] one cycle after PREADY, rsp_rdata = 0.
- PRESET pulse during ACCESS of req 0 -> PSEL = PENABLE = 0 immediately, no rsp_valid. After release, req 0 is granted first again.
- With APB_ARB_TIMEOUT_EN and TIMEOUT = 16, PREADY held low -> PSEL drops after 16 ACCESS cycles, then rsp_valid with rsp_err = 1. Without the macro, the bench sees PSEL held and no response for 100 cycles.
